// File: rtl/dmem_sram.sv
// dmem_sram: single-port 32-bit data memory for the MEM-stage SRAM interface.
// It stores and returns raw words. There is no sign extension and no lane shifting.
//
// Ports
//   clk       clock; all state changes on the rising edge
//   rst       asynchronous active-high reset
//   CS        chip select (1 = access this cycle)
//   WEB[3:0]  active-low byte write enables; WEB == 4'b1111 with CS means read
//   A         word address
//   DI        write data, already placed in its byte lanes
//   DO        registered read data, valid the cycle after the read request
//   busy_clr  high while the post-reset clear runs (INIT_ZERO=1 only);
//             requests are ignored while it is high
//
// Clear FSM
//   state   | meaning
//   S_CLEAR | zeroing mem[clr_cnt], one word per cycle; requests ignored
//   S_READY | normal operation
module dmem_sram #(
  parameter int ADDR_W    = 14,
  parameter int INIT_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CS,
  input  logic [3:0]        WEB,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              busy_clr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  localparam state_e RST_STATE = (INIT_ZERO != 0) ? S_CLEAR : S_READY;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]       do_q, do_d;

  logic [31:0]       mem [DEPTH];

  logic              clr_we;
  logic              ready;
  logic              rd_en;
  logic              wr_req;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [31:0]       rd_word;
  logic [31:0]       lane_mask;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
      do_q      <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      do_q      <= do_d;
    end
  end

  // Next-state logic. The terminal compare is made on the current count, so
  // the last word is written in the same cycle that the FSM leaves S_CLEAR.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == '1) state_d = S_READY;
      end
      default: ;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_clr = 1'b0;
    clr_we   = 1'b0;
    ready    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy_clr = (INIT_ZERO != 0);
        clr_we   = 1'b1;
      end
      default: ready = 1'b1;
    endcase
  end

  // Datapath. A partial write is a read-modify-write of the addressed word,
  // so a read in the following cycle sees the merged word.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 4; i++) lane_mask[8*i +: 8] = {8{~WEB[i]}};

    rd_word = mem[A];
    rd_en   = ready & CS & (WEB == 4'b1111);
    wr_req  = ready & CS & (WEB != 4'b1111);

    do_d    = rd_en ? rd_word : do_q;

    wr_en   = clr_we | wr_req;
    wr_addr = clr_we ? clr_cnt_q : A;
    wr_data = clr_we ? 32'h0 : ((rd_word & ~lane_mask) | (DI & lane_mask));
  end

  // The array has no reset. Clearing it is the job of the clear FSM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign DO = do_q;

endmodule

// File: tb/tb_dmem_sram.sv
// Two instances: u_main (default size, contents kept across reset) and
// u_clr (16 words, cleared after reset).
module tb_dmem_sram;

  logic        clk;
  logic        rst_m, rst_z;

  logic        cs_m;
  logic [3:0]  web_m;
  logic [13:0] a_m;
  logic [31:0] di_m;
  logic [31:0] do_m;
  logic        busy_m;

  logic        cs_z;
  logic [3:0]  web_z;
  logic [3:0]  a_z;
  logic [31:0] di_z;
  logic [31:0] do_z;
  logic        busy_z;

  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] ref_m [int];
  logic [31:0] exp_m = 32'h0;
  logic [31:0] ref_z [16];
  logic [31:0] exp_z = 32'h0;

  dmem_sram #(.ADDR_W(14), .INIT_ZERO(0)) u_main (
    .clk(clk), .rst(rst_m), .CS(cs_m), .WEB(web_m), .A(a_m), .DI(di_m),
    .DO(do_m), .busy_clr(busy_m)
  );

  dmem_sram #(.ADDR_W(4), .INIT_ZERO(1)) u_clr (
    .clk(clk), .rst(rst_z), .CS(cs_z), .WEB(web_z), .A(a_z), .DI(di_z),
    .DO(do_z), .busy_clr(busy_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-lane write: lanes whose enable bit is low take the new byte.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] di,
                                        input logic [3:0] web);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (!web[i]) r[8*i +: 8] = di[8*i +: 8];
    return r;
  endfunction

  // One request to u_main, then a check of DO after the edge.
  task automatic op_m(input logic cs, input logic [3:0] web, input int a,
                      input logic [31:0] di, input string tag);
    cs_m = cs; web_m = web; a_m = a[13:0]; di_m = di;
    @(posedge clk); #1;
    if (cs) begin
      if (web == 4'hF) exp_m = ref_m[a];
      else             ref_m[a] = merge(ref_m.exists(a) ? ref_m[a] : 32'h0, di, web);
    end
    check(tag, do_m, exp_m);
    cs_m = 1'b0;
  endtask

  task automatic op_z(input logic cs, input logic [3:0] web, input int a,
                      input logic [31:0] di, input string tag);
    cs_z = cs; web_z = web; a_z = a[3:0]; di_z = di;
    @(posedge clk); #1;
    if (cs) begin
      if (web == 4'hF) exp_z = ref_z[a];
      else             ref_z[a] = merge(ref_z[a], di, web);
    end
    check(tag, do_z, exp_z);
    cs_z = 1'b0;
  endtask

  // Counts busy cycles while trying to write word 0, which must be ignored.
  task automatic wait_clear_z(input string tag);
    int cnt;
    cnt = 0;
    cs_z = 1'b1; web_z = 4'h0; a_z = 4'h0; di_z = 32'hFFFF_FFFF;
    while (busy_z && cnt < 40) begin
      cnt++;
      @(posedge clk); #1;
    end
    cs_z = 1'b0;
    check(tag, 32'(cnt), 32'd16);
    for (int i = 0; i < 16; i++) ref_z[i] = 32'h0;
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  w;
    logic        c;
    int          a;

    cs_m = 0; web_m = 4'hF; a_m = '0; di_m = '0;
    cs_z = 0; web_z = 4'hF; a_z = '0; di_z = '0;
    rst_m = 1'b1; rst_z = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_do_main",   do_m, 32'h0);
    check("rst_busy_main", 32'(busy_m), 32'd0);
    check("rst_do_clr",    do_z, 32'h0);
    check("rst_busy_clr",  32'(busy_z), 32'd1);
    rst_m = 1'b0; rst_z = 1'b0;

    // ---- clear instance: first clear, then readback, then a second clear
    wait_clear_z("clear_len_1");
    for (int i = 0; i < 16; i++) op_z(1, 4'hF, i, 0, "clr_read_zero_1");
    for (int i = 0; i < 16; i++) op_z(1, 4'h0, i, $urandom, "clr_write");
    for (int i = 0; i < 16; i++) op_z(1, 4'hF, i, 0, "clr_read_data");
    #2 rst_z = 1'b1;
    #1;
    exp_z = 32'h0;
    check("clr_rst_do",   do_z, 32'h0);
    check("clr_rst_busy", 32'(busy_z), 32'd1);
    #2 rst_z = 1'b0;
    wait_clear_z("clear_len_2");
    op_z(1, 4'h0, 0, 32'hCAFE_0000, "clr_first_req");
    for (int i = 0; i < 16; i++) op_z(1, 4'hF, i, 0, "clr_read_zero_2");
    check("clr_word0_const", ref_z[0], 32'hCAFE_0000);

    // ---- main instance: directed cases
    op_m(1, 4'h0, 5, 32'h1234_5678, "sw_a5");
    op_m(1, 4'hF, 5, 0, "lw_a5");
    check("lw_a5_const", do_m, 32'h1234_5678);
    op_m(0, 4'hF, 5, 0, "hold_1");
    op_m(0, 4'h0, 7, 32'hFFFF_FFFF, "hold_cs0_web0");

    op_m(1, 4'h0, 9, 32'hAABB_CCDD, "pre_a9");
    op_m(1, 4'b1101, 9, 32'h0000_EE00, "sb_lane1");
    op_m(1, 4'b0011, 9, 32'h1122_0000, "sh_upper");
    op_m(1, 4'hF, 9, 0, "lw_a9");
    check("merge_const", do_m, 32'h1122_EEDD);

    op_m(1, 4'hF, 5, 0, "lw_a5_again");
    op_m(1, 4'h0, 6, 32'h5555_AAAA, "sw_a6_do_hold");
    check("do_hold_const", do_m, 32'h1234_5678);

    op_m(1, 4'h0, 0, 32'h0000_0A0A, "sw_a0");
    op_m(1, 4'h0, 1, 32'h1111_B1B1, "sw_a1");
    op_m(1, 4'h0, 2, 32'h2222_C2C2, "sw_a2");
    op_m(1, 4'hF, 0, 0, "b2b_a0");
    op_m(1, 4'hF, 1, 0, "b2b_a1");
    op_m(1, 4'hF, 2, 0, "b2b_a2");
    check("b2b_a2_const", do_m, 32'h2222_C2C2);

    op_m(1, 4'b0101, 1, 32'hDEAD_BEEF, "noncontig_wr");
    op_m(1, 4'hF, 1, 0, "noncontig_rd");
    check("noncontig_const", do_m, 32'hDE11_BEB1);

    // ---- randomized traffic over a preloaded window
    for (int i = 0; i < 32; i++) op_m(1, 4'h0, i, $urandom, "rnd_preload");
    for (int k = 0; k < 300; k++) begin
      c = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      a = $urandom_range(0, 31);
      d = $urandom;
      op_m(c, w, a, d, "rnd_op");
    end
    for (int i = 0; i < 32; i++) op_m(1, 4'hF, i, 0, "rnd_sweep");

    // ---- asynchronous reset mid-cycle with DO showing data
    op_m(1, 4'h0, 3, 32'hDEAD_BEEF, "sw_a3");
    op_m(1, 4'hF, 3, 0, "lw_a3");
    check("lw_a3_const", do_m, 32'hDEAD_BEEF);
    #2 rst_m = 1'b1;
    #1;
    exp_m = 32'h0;
    check("async_rst_do",   do_m, 32'h0);
    check("async_rst_busy", 32'(busy_m), 32'd0);
    #2 rst_m = 1'b0;
    op_m(0, 4'hF, 0, 0, "post_rst_idle");
    op_m(1, 4'hF, 3, 0, "post_rst_keep");
    op_m(1, 4'hF, 9, 0, "post_rst_keep_a9");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_sram.md
# dmem_sram

Synchronous single-port data-memory responder that serves the pipeline's MEM-stage SRAM interface. It accepts chip-select, active-low per-byte write enables, a word address and lane-aligned write data, and returns registered read data one cycle later. The block performs no sign extension or lane shifting; it stores and returns raw 32-bit words. The load formatter downstream handles extension and alignment.

## Interface
- ADDR_W, 14: word-address width; depth = 2**ADDR_W words of 32 bits.
- INIT_ZERO, 0: when 1, the array is cleared by reset; when 0, array contents are untouched by reset.

- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- CS  in  1  chip select; 1 = access this cycle.
- WEB  in  4  active-low byte write enables; WEB[i]=0 writes byte lane i (DI[8i+7:8i]).
- A  in  ADDR_W  word address (byte address bits [ADDR_W+1:2]).
- DI  in  32  write data, already placed in the correct byte lanes.
- DO  out  32  registered read data.
- busy_clr  out  1  high while the INIT_ZERO clear sequence runs; requests are ignored while high.

## Operation
- Request decode, sampled each rising edge:
  - Idle: CS=0. No array change; DO holds.
  - Read: CS=1, WEB=4'b1111. DO <= mem[A].
  - Write: CS=1, WEB≠4'b1111. For each i with WEB[i]=0: mem[A][8i+7:8i] <= DI[8i+7:8i]. Lanes with WEB[i]=1 are unchanged. DO holds its previous value.
- Partial patterns are legal writes. Examples: 4'b1110 (SB lane 0), 4'b0011 (SH upper half), 4'b0000 (SW). Non-contiguous masks such as 4'b0101 are legal and honoured lane-by-lane.
- Read-after-write to the same address in consecutive cycles returns the newly written bytes merged with the untouched old bytes. There is no stale data.
- Clear state machine, active only when INIT_ZERO=1:
  - States: CLEAR and READY.
  - Reset enters CLEAR with the counter at 0.
  - In CLEAR, each cycle writes 0 to mem[counter] and increments the counter. busy_clr=1; CS is ignored.
  - When the counter reaches 2**ADDR_W-1 and that word is written, the next state is READY. busy_clr=0.
  - The counter is ADDR_W bits wide; the terminal compare happens before wrap, so there is no extra cycle.
  - With INIT_ZERO=0 the block is permanently READY and busy_clr is tied 0.

## Timing
- Reset values: DO=32'h0 and busy_clr=INIT_ZERO. The clear-state register is CLEAR if INIT_ZERO, else READY.
- Reset asserts asynchronously. DO clears immediately regardless of the clock.
- Reset asserted mid-write: the write in progress at that edge is not guaranteed. The array is otherwise unaffected unless INIT_ZERO=1, in which case the clear restarts from word 0.
- Read latency: 1 cycle. A request presented in cycle n appears on DO after edge n and is valid throughout cycle n+1.
- Back-to-back reads to different addresses: DO updates every cycle, throughput 1 word/cycle.
- Write latency: array is updated at edge n, visible to a read issued in cycle n+1.
- A write in cycle n and a read of the same address in cycle n+1 give DO, in cycle n+2, equal to the merged data.
- Clear duration with INIT_ZERO=1: exactly 2**ADDR_W cycles after reset deassertion. The first accepted request is in cycle 2**ADDR_W.
- No stall or handshake: every READY-state request completes with fixed timing.

## Test plan
- Reset: assert rst mid-cycle with DO=32'hDEADBEEF -> DO=0 before the next edge; busy_clr=INIT_ZERO.
- Full-word write/read: write A=5, DI=32'h12345678, WEB=0000; read A=5 next cycle -> DO=32'h12345678 one cycle later, held while CS=0.
- Byte/half merge: preload A=9 with 32'hAABBCCDD. Write WEB=1101 with DI=32'h0000EE00, then WEB=0011 with DI=32'h11220000. Read A=9 -> 32'h1122EEDD.
- Write does not disturb DO: read A=5 (DO=32'h12345678), then write A=6. DO stays 32'h12345678 through the write cycle.
- Back-to-back reads A=0,1,2 with distinct contents -> DO presents the three words on three consecutive cycles, each one cycle after its request.
- INIT_ZERO=1, ADDR_W=4: write mem via the pipeline, then pulse rst -> busy_clr high 16 cycles with requests ignored. Afterwards a read of any address returns 0.
